// File: rtl/mem_stage_if.sv
// EX-side inputs and MEM/WB-side outputs of the memory-access stage.
interface mem_stage_if;
  logic [10:0] WB_MEM_EX;
  logic [5:0]  EX_Opcode;
  logic [31:0] EX_ALU_RESULT;
  logic [31:0] EX_RT_DATA;
  logic [4:0]  EX_RD;
  logic [31:0] EX_PC_4;

  logic [4:0]  WB_MEM;
  logic [5:0]  MEM_Opcode;
  logic [31:0] MEM_ALU_RESULT;
  logic [31:0] MEM_RT_DATA;
  logic [4:0]  MEM_RD;
  logic [31:0] MEM_PC_4;
  logic [31:0] MEM_RD_DATA;

  logic [2:0]  WB;
  logic [31:0] WB_ALU_RESULT;
  logic [31:0] WB_RD_Data;
  logic [4:0]  WB_RD;
  logic [31:0] WB_PC_4;

  modport master (
    output WB_MEM_EX, EX_Opcode, EX_ALU_RESULT, EX_RT_DATA, EX_RD, EX_PC_4,
    input  WB_MEM, MEM_Opcode, MEM_ALU_RESULT, MEM_RT_DATA, MEM_RD, MEM_PC_4,
           MEM_RD_DATA, WB, WB_ALU_RESULT, WB_RD_Data, WB_RD, WB_PC_4
  );

  modport slave (
    input  WB_MEM_EX, EX_Opcode, EX_ALU_RESULT, EX_RT_DATA, EX_RD, EX_PC_4,
    output WB_MEM, MEM_Opcode, MEM_ALU_RESULT, MEM_RT_DATA, MEM_RD, MEM_PC_4,
           MEM_RD_DATA, WB, WB_ALU_RESULT, WB_RD_Data, WB_RD, WB_PC_4
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS MEM stage: EX/MEM register, 256x32 little-endian data memory with
// byte/halfword access, and MEM/WB register.
module mem_stage (
  input  logic        CLK,
  input  logic        RESET,
  mem_stage_if.slave  bus
);
  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   word;
  logic          mem_read;
  logic          mem_write;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   rd_data;
  logic [31:0]   wr_word;
  logic          unused_ex;

  assign unused_ex = ^bus.WB_MEM_EX[5:0];

  assign idx       = bus.MEM_ALU_RESULT[9:2];
  assign lane      = bus.MEM_ALU_RESULT[1:0];
  assign word      = mem[idx];
  assign mem_write = bus.WB_MEM[0];
  assign mem_read  = bus.WB_MEM[1];

  // EX/MEM pipeline register
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      bus.WB_MEM         <= '0;
      bus.MEM_Opcode     <= '0;
      bus.MEM_ALU_RESULT <= '0;
      bus.MEM_RT_DATA    <= '0;
      bus.MEM_RD         <= '0;
      bus.MEM_PC_4       <= '0;
    end else begin
      bus.WB_MEM         <= bus.WB_MEM_EX[10:6];
      bus.MEM_Opcode     <= bus.EX_Opcode;
      bus.MEM_ALU_RESULT <= bus.EX_ALU_RESULT;
      bus.MEM_RT_DATA    <= bus.EX_RT_DATA;
      bus.MEM_RD         <= bus.EX_RD;
      bus.MEM_PC_4       <= bus.EX_PC_4;
    end
  end

  // Load path: reads the pre-write word, so a same-cycle store never bypasses
  always_comb begin
    rd_byte = word[{lane, 3'b000} +: 8];
    rd_half = lane[1] ? word[31:16] : word[15:0];
    rd_data = '0;
    if (mem_read) begin
      case (bus.MEM_Opcode)
        OP_LB:   rd_data = {{24{rd_byte[7]}}, rd_byte};
        OP_LBU:  rd_data = {24'b0, rd_byte};
        OP_LH:   rd_data = {{16{rd_half[15]}}, rd_half};
        OP_LHU:  rd_data = {16'b0, rd_half};
        default: rd_data = word;
      endcase
    end
  end

  assign bus.MEM_RD_DATA = rd_data;

  // Store merge: unselected lanes keep their current contents
  always_comb begin
    wr_word = word;
    case (bus.MEM_Opcode)
      OP_SB:   wr_word[{lane, 3'b000} +: 8] = bus.MEM_RT_DATA[7:0];
      OP_SH: begin
        if (lane[1]) wr_word[31:16] = bus.MEM_RT_DATA[15:0];
        else         wr_word[15:0]  = bus.MEM_RT_DATA[15:0];
      end
      default: wr_word = bus.MEM_RT_DATA;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i[AW-1:0]] <= '0;
      end
    end else if (mem_write) begin
      mem[idx] <= wr_word;
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      bus.WB            <= '0;
      bus.WB_ALU_RESULT <= '0;
      bus.WB_RD_Data    <= '0;
      bus.WB_RD         <= '0;
      bus.WB_PC_4       <= '0;
    end else begin
      bus.WB            <= bus.WB_MEM[4:2];
      bus.WB_ALU_RESULT <= bus.MEM_ALU_RESULT;
      bus.WB_RD_Data    <= rd_data;
      bus.WB_RD         <= bus.MEM_RD;
      bus.WB_PC_4       <= bus.MEM_PC_4;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: byte-addressed reference model, per-cycle compare,
// directed literal checks and randomized instruction streams.
module tb_mem_stage;
  logic CLK = 1'b0;
  logic RESET;

  mem_stage_if bus();

  mem_stage dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0]  wbm;
    logic [5:0]  op;
    logic [31:0] alu;
    logic [31:0] rt;
    logic [4:0]  rd;
    logic [31:0] pc4;
  } ex_t;

  typedef struct packed {
    logic [2:0]  wb;
    logic [31:0] alu;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [31:0] pc4;
  } wb_t;

  logic [7:0] m_bytes [1024];
  ex_t m_ex;
  wb_t m_wb;
  logic started = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // What a load must return, computed over a flat 1 KiB byte array
  function automatic logic [31:0] model_load(input ex_t e);
    int unsigned a;
    logic [7:0] b;
    logic [15:0] h;
    a = int'(e.alu[9:0]);
    if (!e.wbm[1]) return 32'h0;
    case (e.op)
      6'b100000, 6'b100100: begin
        b = m_bytes[a];
        if (e.op == 6'b100000 && b >= 8'd128) return {24'hFFFFFF, b};
        return {24'h0, b};
      end
      6'b100001, 6'b100101: begin
        h = {m_bytes[(a & ~32'd1) + 1], m_bytes[a & ~32'd1]};
        if (e.op == 6'b100001 && h >= 16'h8000) return {16'hFFFF, h};
        return {16'h0, h};
      end
      default: begin
        a = a & ~32'd3;
        return {m_bytes[a+3], m_bytes[a+2], m_bytes[a+1], m_bytes[a]};
      end
    endcase
  endfunction

  // Reference model advances on every rising edge from the bench-driven inputs
  always @(posedge CLK) begin
    int unsigned a;
    if (!RESET) begin
      for (int i = 0; i < 1024; i++) m_bytes[i] <= 8'h0;
      m_ex    <= '0;
      m_wb    <= '0;
      started <= 1'b1;
    end else begin
      m_wb <= '{wb: m_ex.wbm[4:2], alu: m_ex.alu, data: model_load(m_ex),
                rd: m_ex.rd, pc4: m_ex.pc4};
      if (m_ex.wbm[0]) begin
        a = int'(m_ex.alu[9:0]);
        case (m_ex.op)
          6'b101000: m_bytes[a] <= m_ex.rt[7:0];
          6'b101001: begin
            m_bytes[a & ~32'd1]       <= m_ex.rt[7:0];
            m_bytes[(a & ~32'd1) + 1] <= m_ex.rt[15:8];
          end
          default: begin
            a = a & ~32'd3;
            m_bytes[a]   <= m_ex.rt[7:0];
            m_bytes[a+1] <= m_ex.rt[15:8];
            m_bytes[a+2] <= m_ex.rt[23:16];
            m_bytes[a+3] <= m_ex.rt[31:24];
          end
        endcase
      end
      m_ex <= '{wbm: bus.WB_MEM_EX[10:6], op: bus.EX_Opcode, alu: bus.EX_ALU_RESULT,
                rt: bus.EX_RT_DATA, rd: bus.EX_RD, pc4: bus.EX_PC_4};
    end
  end

  // Compare every output against the model mid-cycle
  always @(negedge CLK) begin
    if (started) begin
      check("wb_mem",         32'(bus.WB_MEM),      32'(m_ex.wbm));
      check("mem_opcode",     32'(bus.MEM_Opcode),  32'(m_ex.op));
      check("mem_alu_result", bus.MEM_ALU_RESULT,   m_ex.alu);
      check("mem_rt_data",    bus.MEM_RT_DATA,      m_ex.rt);
      check("mem_rd",         32'(bus.MEM_RD),      32'(m_ex.rd));
      check("mem_pc_4",       bus.MEM_PC_4,         m_ex.pc4);
      check("mem_rd_data",    bus.MEM_RD_DATA,      model_load(m_ex));
      check("wb",             32'(bus.WB),          32'(m_wb.wb));
      check("wb_alu_result",  bus.WB_ALU_RESULT,    m_wb.alu);
      check("wb_rd_data",     bus.WB_RD_Data,       m_wb.data);
      check("wb_rd",          32'(bus.WB_RD),       32'(m_wb.rd));
      check("wb_pc_4",        bus.WB_PC_4,          m_wb.pc4);
    end
  end

  localparam logic [10:0] C_LOAD  = 11'b01110000100;
  localparam logic [10:0] C_STORE = 11'b00001000100;
  localparam logic [10:0] C_ALU   = 11'b00100000100;
  localparam logic [10:0] C_RMW   = 11'b00011000000;

  task automatic issue(input logic [10:0] w, input logic [5:0] op, input logic [31:0] alu,
                       input logic [31:0] rt, input logic [4:0] rd, input logic [31:0] pc4);
    bus.WB_MEM_EX     = w;
    bus.EX_Opcode     = op;
    bus.EX_ALU_RESULT = alu;
    bus.EX_RT_DATA    = rt;
    bus.EX_RD         = rd;
    bus.EX_PC_4       = pc4;
    @(posedge CLK);
    #1;
  endtask

  task automatic nop();
    issue(11'h0, 6'h0, 32'h0, 32'h0, 5'h0, 32'h0);
  endtask

  logic [5:0] ops [10];

  initial begin
    ops = '{6'b100011, 6'b100000, 6'b100100, 6'b100001, 6'b100101,
            6'b101011, 6'b101000, 6'b101001, 6'b001000, 6'b000000};
    RESET = 1'b0;
    bus.WB_MEM_EX = '0; bus.EX_Opcode = '0; bus.EX_ALU_RESULT = '0;
    bus.EX_RT_DATA = '0; bus.EX_RD = '0; bus.EX_PC_4 = '0;
    nop();
    nop();
    RESET = 1'b1;
    check("rst_wb_mem",  32'(bus.WB_MEM), 32'h0);
    check("rst_wb",      32'(bus.WB),     32'h0);
    check("rst_wb_data", bus.WB_RD_Data,  32'h0);

    issue(C_LOAD, 6'b100011, 32'h3C, 32'h0, 5'd1, 32'h0);
    check("rst_lw_zero", bus.MEM_RD_DATA, 32'h0);

    issue(C_STORE, 6'b101011, 32'd4, 32'd40, 5'd0, 32'd0);
    issue(C_LOAD,  6'b100011, 32'd4, 32'd0,  5'd6, 32'd4);
    check("sw_lw_fwd", bus.MEM_RD_DATA, 32'd40);
    nop();
    check("sw_lw_wb",      32'(bus.WB),    32'b011);
    check("sw_lw_wb_data", bus.WB_RD_Data, 32'd40);
    check("sw_lw_wb_rd",   32'(bus.WB_RD), 32'd6);
    check("sw_lw_wb_pc4",  bus.WB_PC_4,    32'd4);

    issue(C_ALU, 6'b001000, 32'd20, 32'd60, 5'd3, 32'd8);
    nop();
    check("addi_wb",      32'(bus.WB),       32'b001);
    check("addi_wb_alu",  bus.WB_ALU_RESULT, 32'd20);
    check("addi_wb_data", bus.WB_RD_Data,    32'd0);
    check("addi_wb_pc4",  bus.WB_PC_4,       32'd8);
    issue(C_LOAD, 6'b100011, 32'd4, 32'd0, 5'd6, 32'd0);
    check("addi_mem_kept", bus.MEM_RD_DATA, 32'd40);

    issue(C_STORE, 6'b101011, 32'd8, 32'h80FF7F01, 5'd0, 32'd0);
    issue(C_LOAD, 6'b100000, 32'd11, 32'd0, 5'd2, 32'd0);
    check("lb_11",  bus.MEM_RD_DATA, 32'hFFFFFF80);
    issue(C_LOAD, 6'b100100, 32'd11, 32'd0, 5'd2, 32'd0);
    check("lbu_11", bus.MEM_RD_DATA, 32'h00000080);
    issue(C_LOAD, 6'b100001, 32'd10, 32'd0, 5'd2, 32'd0);
    check("lh_10",  bus.MEM_RD_DATA, 32'hFFFF80FF);
    issue(C_LOAD, 6'b100101, 32'd8, 32'd0, 5'd2, 32'd0);
    check("lhu_8",  bus.MEM_RD_DATA, 32'h00007F01);
    issue(C_STORE, 6'b101000, 32'd9, 32'h000000AA, 5'd0, 32'd0);
    issue(C_LOAD, 6'b100011, 32'd8, 32'd0, 5'd2, 32'd0);
    check("sb_merge", bus.MEM_RD_DATA, 32'h80FFAA01);

    issue(C_STORE, 6'b101011, 32'h404, 32'd7, 5'd0, 32'd0);
    issue(C_LOAD, 6'b100011, 32'd4, 32'd0, 5'd2, 32'd0);
    check("wrap", bus.MEM_RD_DATA, 32'd7);

    issue(C_RMW, 6'b101011, 32'd4, 32'd99, 5'd0, 32'd0);
    check("rmw_old", bus.MEM_RD_DATA, 32'd7);
    issue(C_LOAD, 6'b100011, 32'd4, 32'd0, 5'd2, 32'd0);
    check("rmw_new", bus.MEM_RD_DATA, 32'd99);

    issue(C_STORE, 6'b101011, 32'd12, 32'h1234, 5'd0, 32'd16);
    RESET = 1'b0;
    nop();
    RESET = 1'b1;
    check("midrst_wb_mem", 32'(bus.WB_MEM),   32'h0);
    check("midrst_alu",    bus.MEM_ALU_RESULT, 32'h0);
    check("midrst_wb_pc4", bus.WB_PC_4,        32'h0);
    issue(C_LOAD, 6'b100011, 32'd12, 32'd0, 5'd2, 32'd0);
    check("midrst_no_store", bus.MEM_RD_DATA, 32'h0);
    issue(C_LOAD, 6'b100011, 32'd4, 32'd0, 5'd2, 32'd0);
    check("midrst_cleared", bus.MEM_RD_DATA, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] alu;
      logic [10:0] w;
      alu = $urandom();
      if ($urandom_range(0, 3) != 0) alu[9:5] = 5'b0;
      w = 11'($urandom());
      if ($urandom_range(0, 1) == 0) w[7:6] = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      RESET = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      issue(w, ($urandom_range(0, 9) == 9) ? 6'($urandom()) : ops[$urandom_range(0, 8)],
            alu, $urandom(), 5'($urandom()), $urandom());
    end
    RESET = 1'b1;
    nop();
    nop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
